// File: rtl/apb_reg_slave.sv
// apb_reg_slave: APB completer with a register bank, transfer counter, sticky protocol-error flag
module apb_reg_slave #(
  parameter int AWIDTH = 4,
  parameter int DWIDTH = 8
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [AWIDTH-1:0] paddr,
  input  logic [DWIDTH-1:0] pwdata,
  output logic [DWIDTH-1:0] prdata,
  output logic [DWIDTH-1:0] ctrl_o,
  output logic              err_o
);
  localparam int N = 2 ** AWIDTH;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;
  state_e state_q, state_d;
  logic [AWIDTH-1:0] addr_q;
  logic write_q;
  logic [DWIDTH-1:0] mem_q [N-1];
  logic [DWIDTH-1:0] cnt_q, cnt_d, prdata_q, prdata_d;
  logic err_q, err_d;
  logic setup, access, done, wr, top;
  assign setup = psel & ~penable;
  assign access = psel & penable;
  assign top = &paddr;
  assign wr = done & pwrite;
  always_comb begin
    state_d = state_q;
    err_d = err_q;
    done = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = setup ? SETUP : IDLE;
        err_d = err_q | access;
      end
      SETUP:
        if (access && paddr == addr_q && pwrite == write_q) begin
          state_d = ACCESS;
          done = 1'b1;
        end else begin
          state_d = setup ? SETUP : IDLE;
          err_d = err_q | ~setup;
        end
      ACCESS: begin
        state_d = setup ? SETUP : IDLE;
        err_d = err_q | access;
      end
      default: state_d = IDLE;
    endcase
    if (wr && top) err_d = 1'b0;
    cnt_d = (wr && top) ? '0 : cnt_q + DWIDTH'(done);
    // the top address reads the counter as it stood before this transfer is counted
    prdata_d = (setup && !pwrite) ? (top ? cnt_q : mem_q[paddr]) : prdata_q;
  end
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= IDLE;
      addr_q <= '0;
      write_q <= 1'b0;
      cnt_q <= '0;
      err_q <= 1'b0;
      prdata_q <= '0;
      for (int i = 0; i < N - 1; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (setup) begin
        addr_q <= paddr;
        write_q <= pwrite;
      end
      cnt_q <= cnt_d;
      err_q <= err_d;
      prdata_q <= prdata_d;
      if (wr && !top) mem_q[paddr] <= pwdata;
    end
  end
  assign prdata = prdata_q;
  assign ctrl_o = mem_q[0];
  assign err_o = err_q;
endmodule

// File: tb/tb_apb_reg_slave.sv
// tb_apb_reg_slave: directed vector table plus hand-written protocol corner sequences
module tb_apb_reg_slave;
  logic clk = 1'b0, rst_n = 1'b0;
  logic psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [3:0] paddr = '0;
  logic [7:0] pwdata = '0, prdata, ctrl_o, rd;
  logic err_o;
  int n_tests = 0, n_fail = 0;
  typedef struct {
    logic       wr;
    logic [3:0] addr;
    logic [7:0] data;
    logic [7:0] exp_rd;
    logic [7:0] exp_ctrl;
  } vec_t;
  vec_t vecs[13];

  apb_reg_slave #(.AWIDTH(4), .DWIDTH(8)) dut (
    .pclk(clk), .presetn(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .ctrl_o(ctrl_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    psel = 1'b0;
    penable = 1'b0;
  endtask

  task automatic apb_write(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(negedge clk);
    penable = 1'b1;
    idle();
  endtask

  task automatic apb_read(input logic [3:0] a, output logic [7:0] d);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(negedge clk);
    penable = 1'b1;
    idle();
    d = prdata;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 4'd3,  8'hA5, 8'h00, 8'h00};
    vecs[1]  = '{1'b0, 4'd3,  8'h00, 8'hA5, 8'h00};
    vecs[2]  = '{1'b1, 4'd0,  8'h3C, 8'h00, 8'h3C};
    vecs[3]  = '{1'b0, 4'd0,  8'h00, 8'h3C, 8'h3C};
    vecs[4]  = '{1'b0, 4'd15, 8'h00, 8'h06, 8'h3C};
    vecs[5]  = '{1'b1, 4'd15, 8'h99, 8'h00, 8'h3C};
    vecs[6]  = '{1'b1, 4'd1,  8'h01, 8'h00, 8'h3C};
    vecs[7]  = '{1'b1, 4'd2,  8'h02, 8'h00, 8'h3C};
    vecs[8]  = '{1'b0, 4'd1,  8'h00, 8'h01, 8'h3C};
    vecs[9]  = '{1'b0, 4'd2,  8'h00, 8'h02, 8'h3C};
    vecs[10] = '{1'b1, 4'd14, 8'hEE, 8'h00, 8'h3C};
    vecs[11] = '{1'b0, 4'd15, 8'h00, 8'h05, 8'h3C};
    vecs[12] = '{1'b0, 4'd14, 8'h00, 8'hEE, 8'h3C};
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    // dirty every output, then reset in the middle of a write to addr 2
    apb_write(4'd2, 8'h77);
    apb_write(4'd0, 8'h5A);
    apb_read(4'd2, rd);
    chk("pre_reset_rd2", rd, 8'h77);
    @(negedge clk);
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 4'd4; pwdata = 8'h44;
    idle();
    chk("pre_reset_err", {7'd0, err_o}, 8'h01);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'd2; pwdata = 8'h99;
    @(negedge clk);
    penable = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_prdata", prdata, 8'h00);
    chk("rst_ctrl", ctrl_o, 8'h00);
    chk("rst_err", {7'd0, err_o}, 8'h00);
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    apb_read(4'd2, rd);
    chk("rst_rd2", rd, 8'h00);
    apb_read(4'd15, rd);
    chk("rst_cnt", rd, 8'h01);
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].wr) apb_write(vecs[i].addr, vecs[i].data);
      else begin
        apb_read(vecs[i].addr, rd);
        chk($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
      end
      chk($sformatf("vec%0d_ctrl", i), ctrl_o, vecs[i].exp_ctrl);
      chk($sformatf("vec%0d_err", i), {7'd0, err_o}, 8'h00);
    end
    // read data holds through idle cycles and through a write transfer
    apb_read(4'd3, rd);
    repeat (2) @(negedge clk);
    chk("hold_idle", prdata, 8'hA5);
    apb_write(4'd5, 8'h55);
    chk("hold_write", prdata, 8'hA5);
    // access with no setup
    apb_write(4'd15, 8'h00);
    @(negedge clk);
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 4'd4; pwdata = 8'h44;
    idle();
    chk("noset_err", {7'd0, err_o}, 8'h01);
    apb_read(4'd4, rd);
    chk("noset_rd4", rd, 8'h00);
    apb_write(4'd15, 8'h00);
    chk("clear_err", {7'd0, err_o}, 8'h00);
    // address changes between setup and access
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'd4; pwdata = 8'h66;
    @(negedge clk);
    penable = 1'b1; paddr = 4'd5;
    idle();
    chk("addrchg_err", {7'd0, err_o}, 8'h01);
    apb_read(4'd4, rd);
    chk("addrchg_rd4", rd, 8'h00);
    apb_read(4'd5, rd);
    chk("addrchg_rd5", rd, 8'h55);
    apb_read(4'd15, rd);
    chk("addrchg_cnt", rd, 8'h02);
    // penable held for two edges
    apb_write(4'd15, 8'h00);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'd6; pwdata = 8'h11;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    idle();
    chk("wait_err", {7'd0, err_o}, 8'h01);
    apb_write(4'd15, 8'h00);
    chk("clear2_err", {7'd0, err_o}, 8'h00);
    apb_write(4'd8, 8'h88);
    apb_read(4'd8, rd);
    chk("legal_rd8", rd, 8'h88);
    chk("legal_err", {7'd0, err_o}, 8'h00);
    // back-to-back write then read of the same address
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'd6; pwdata = 8'h13;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    penable = 1'b0; pwrite = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    idle();
    chk("b2b_rd6", prdata, 8'h13);
    apb_read(4'd15, rd);
    chk("b2b_cnt", rd, 8'h04);
    chk("b2b_err", {7'd0, err_o}, 8'h00);
    // counter wrap
    apb_write(4'd15, 8'h00);
    for (int i = 0; i < 255; i++) apb_read(4'd0, rd);
    apb_read(4'd15, rd);
    chk("cnt_ff", rd, 8'hFF);
    apb_read(4'd15, rd);
    chk("cnt_wrap", rd, 8'h00);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
